// File: rtl/full_adder_pkg.sv
// Shared definitions for the full_adder block: width limit and the 1-bit
// sum/carry function used by every leaf cell.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic co;
    logic s;
  } fa_bit_t;

  function automatic fa_bit_t fa_bit(input logic a, input logic b, input logic cin);
    fa_bit_t r;
    r.s  = a ^ b ^ cin;
    r.co = (a & b) | (a & cin) | (b & cin);
    return r;
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// 1-bit combinational full-adder cell; the leaf of the ripple-carry chain.
module fa_cell
  import full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  fa_bit_t res;

  assign res = fa_bit(a, b, cin);
  assign s   = res.s;
  assign co  = res.co;

endmodule

// File: rtl/full_adder.sv
// Parameterised ripple-carry adder with an optional one-cycle registered copy.
// Define FULL_ADDER_OVF_EN to add the signed-overflow outputs ovf / ovf_q.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_vld,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_vld
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  // c[i] is the carry into cell i; c[WIDTH] is the final carry-out.
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .cin(c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[WIDTH];

`ifdef FULL_ADDER_OVF_EN
  // Carries into and out of the sign bit disagree exactly on signed overflow.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];
`endif

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_reg_d, sum_reg_q;
    logic             cout_reg_d, cout_reg_q;
    logic             vld_d, vld_q;
`ifdef FULL_ADDER_OVF_EN
    logic             ovf_reg_d, ovf_reg_q;
`endif

    always_comb begin
      // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
      sum_reg_d  = sum_reg_q;
      cout_reg_d = cout_reg_q;
      vld_d      = in_vld;
`ifdef FULL_ADDER_OVF_EN
      ovf_reg_d  = ovf_reg_q;
`endif
      if (in_vld) begin
        sum_reg_d  = sum;
        cout_reg_d = cout;
`ifdef FULL_ADDER_OVF_EN
        ovf_reg_d  = ovf;
`endif
      end
    end

    // NOTE: state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sum_reg_q  <= '0;
        cout_reg_q <= 1'b0;
        vld_q      <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
        ovf_reg_q  <= 1'b0;
`endif
      end else begin
        sum_reg_q  <= sum_reg_d;
        cout_reg_q <= cout_reg_d;
        vld_q      <= vld_d;
`ifdef FULL_ADDER_OVF_EN
        ovf_reg_q  <= ovf_reg_d;
`endif
      end
    end

    assign sum_q   = sum_reg_q;
    assign cout_q  = cout_reg_q;
    assign out_vld = vld_q;
`ifdef FULL_ADDER_OVF_EN
    assign ovf_q   = ovf_reg_q;
`endif
  end else begin : g_no_reg
    assign sum_q   = '0;
    assign cout_q  = 1'b0;
    assign out_vld = 1'b0;
`ifdef FULL_ADDER_OVF_EN
    assign ovf_q   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: directed WIDTH=1/4 vectors, registered
// path and async reset on WIDTH=4, randomized WIDTH=8 with a scoreboard.
module tb_full_adder;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- WIDTH=1 instance ----------------
  logic a1, b1, cin1, in_vld1;
  logic sum1, cout1, sum_q1, cout_q1, out_vld1;
`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf_q1;
`endif

  full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_vld(in_vld1),
    .sum(sum1), .cout(cout1), .sum_q(sum_q1), .cout_q(cout_q1), .out_vld(out_vld1)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1), .ovf_q(ovf_q1)
`endif
  );

  // ---------------- WIDTH=4 instance ----------------
  logic [3:0] a4, b4, sum4, sum_q4;
  logic       cin4, in_vld4, cout4, cout_q4, out_vld4;
`ifdef FULL_ADDER_OVF_EN
  logic ovf4, ovf_q4;
`endif

  full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .in_vld(in_vld4),
    .sum(sum4), .cout(cout4), .sum_q(sum_q4), .cout_q(cout_q4), .out_vld(out_vld4)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf4), .ovf_q(ovf_q4)
`endif
  );

  // ---------------- WIDTH=8 instance ----------------
  logic [7:0] a8, b8, sum8, sum_q8;
  logic       cin8, in_vld8, cout8, cout_q8, out_vld8;
`ifdef FULL_ADDER_OVF_EN
  logic ovf8, ovf_q8;
`endif

  full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_vld(in_vld8),
    .sum(sum8), .cout(cout8), .sum_q(sum_q8), .cout_q(cout_q8), .out_vld(out_vld8)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf8), .ovf_q(ovf_q8)
`endif
  );

  // ---------------- Scoreboard for the WIDTH=8 registered path ----------------
  typedef struct {
    logic       vld;
    logic [8:0] res;
  } sb_t;

  sb_t sb[$];

  always @(posedge clk) begin
    sb_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("w8_out_vld", 64'(out_vld8), 64'(e.vld));
      check("w8_reg_result", 64'({cout_q8, sum_q8}), 64'(e.res));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- Stimulus ----------------
  logic [3:0] v4_a   [3] = '{4'hF, 4'h7, 4'h5};
  logic [3:0] v4_b   [3] = '{4'h1, 4'h8, 4'h2};
  logic       v4_cin [3] = '{1'b0, 1'b1, 1'b0};
  logic [3:0] v4_sum [3] = '{4'h0, 4'h0, 4'h7};
  logic       v4_cout[3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    logic [1:0] e2;
    logic [8:0] t9;
    logic [8:0] held8;
    logic [2:0] idx;
    int         waited;

    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; in_vld1 = 1'b0;
    a4 = '0;   b4 = '0;   cin4 = 1'b0; in_vld4 = 1'b0;
    a8 = '0;   b8 = '0;   cin8 = 1'b0; in_vld8 = 1'b0;
    held8 = '0;

    // Reset state of the registered outputs
    repeat (2) @(negedge clk);
    check("rst_sum_q4", 64'(sum_q4), 64'(0));
    check("rst_cout_q4", 64'(cout_q4), 64'(0));
    check("rst_out_vld4", 64'(out_vld4), 64'(0));
    check("rst_out_vld8", 64'(out_vld8), 64'(0));
    check("rst_zero_comb4", 64'({cout4, sum4}), 64'(0));
    rst = 1'b0;

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      {a1, b1, cin1} = idx;
      #10;
      e2 = 2'(a1) + 2'(b1) + 2'(cin1);
      check("w1_sum", 64'(sum1), 64'(e2[0]));
      check("w1_cout", 64'(cout1), 64'(e2[1]));
    end

    // WIDTH=4 directed ripple vectors
    for (int i = 0; i < 3; i++) begin
      a4 = v4_a[i]; b4 = v4_b[i]; cin4 = v4_cin[i];
      #10;
      check("w4_sum", 64'(sum4), 64'(v4_sum[i]));
      check("w4_cout", 64'(cout4), 64'(v4_cout[i]));
    end

    // All-ones boundary
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    #10;
    check("w4_all_ones", 64'({cout4, sum4}), 64'(5'h1F));

`ifdef FULL_ADDER_OVF_EN
    a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
    #10;
    check("w4_ovf_pos", 64'({ovf4, sum4}), 64'(5'h18));
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b0;
    #10;
    check("w4_ovf_none", 64'({ovf4, cout4, sum4}), 64'(6'h1E));
`endif

    // Registered path, WIDTH=4
    @(negedge clk);
    a4 = 4'd3; b4 = 4'd4; cin4 = 1'b1; in_vld4 = 1'b1;
    @(negedge clk);
    check("w4_reg_sum", 64'(sum_q4), 64'(8));
    check("w4_reg_cout", 64'(cout_q4), 64'(0));
    check("w4_reg_vld", 64'(out_vld4), 64'(1));
`ifdef FULL_ADDER_OVF_EN
    check("w4_reg_ovf", 64'(ovf_q4), 64'(1));
`endif
    in_vld4 = 1'b0; a4 = 4'd5;
    @(negedge clk);
    check("w4_hold_sum", 64'(sum_q4), 64'(8));
    check("w4_hold_vld", 64'(out_vld4), 64'(0));

    // Async reset between edges, with a valid result present
    a4 = 4'd3; in_vld4 = 1'b1;
    @(posedge clk);
    #2;
    check("w4_pre_rst_vld", 64'(out_vld4), 64'(1));
    rst = 1'b1;
    #1;
    check("w4_async_sum_q", 64'(sum_q4), 64'(0));
    check("w4_async_cout_q", 64'(cout_q4), 64'(0));
    check("w4_async_vld", 64'(out_vld4), 64'(0));
    check("w4_comb_in_rst", 64'({cout4, sum4}), 64'(8));
    @(posedge clk);
    #1;
    check("w4_rst_discard", 64'(out_vld4), 64'(0));
    check("w4_rst_discard_sum", 64'(sum_q4), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("w4_first_capture_vld", 64'(out_vld4), 64'(1));
    check("w4_first_capture_sum", 64'(sum_q4), 64'(8));
    @(negedge clk);
    in_vld4 = 1'b0;

    // Randomized WIDTH=8 with scoreboard on the registered path
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a8      = 8'($urandom);
      b8      = 8'($urandom);
      cin8    = 1'($urandom_range(0, 1));
      in_vld8 = ($urandom_range(0, 3) != 0);
      t9      = 9'(a8) + 9'(b8) + 9'(cin8);
      if (in_vld8) held8 = t9;
      sb.push_back('{vld: in_vld8, res: held8});
      #1;
      check("w8_comb", 64'({cout8, sum8}), 64'(t9));
`ifdef FULL_ADDER_OVF_EN
      begin
        int s;
        s = int'($signed(a8)) + int'($signed(b8)) + int'(cin8);
        check("w8_ovf", 64'(ovf8), 64'((s > 127) || (s < -128)));
      end
`endif
    end
    @(negedge clk);
    in_vld8 = 1'b0;

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("w8_sb_drained", 64'(sb.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
